// File: rtl/hmac_arb_pkg.sv
// Shared constants and state encoding for the HMAC arbiter.
// Holds width defaults, the watchdog default and FSM states.
package hmac_arb_pkg;

    localparam int MSG_W_DEF   = 1088;
    localparam int KEY_W_DEF   = 128;
    localparam int MAC_W_DEF   = 256;
    localparam int TIMEOUT_DEF = 4095;
    localparam int CNT_W       = 12;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/hmac_arb_rr.sv
// Two-way round-robin selector (combinational).
// pend: pending flags, last: last served; valid: any pending, sel: winner.
module hmac_arb_rr (
    input  logic [1:0] pend,
    input  logic       last,
    output logic       valid,
    output logic       sel
);

    always_comb begin
        valid = |pend;
        sel   = 1'b0;
        unique case (1'b1)
            (&pend):          sel = ~last;
            (pend == 2'b10):  sel = 1'b1;
            default:          sel = 1'b0;
        endcase
    end

endmodule

// File: rtl/hmac_arbiter.sv
// Arbitrates two requesters onto one shared HMAC core.
// Ports: req0/req1 start/key/msg in, ready/mac out; hmac_* to the core; grant/busy/err status.
module hmac_arbiter
    import hmac_arb_pkg::*;
#(
    parameter int MSG_W   = MSG_W_DEF,
    parameter int KEY_W   = KEY_W_DEF,
    parameter int MAC_W   = MAC_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_start,
    input  logic [KEY_W-1:0] req0_key,
    input  logic [MSG_W-1:0] req0_msg,
    output logic             req0_ready,
    output logic [MAC_W-1:0] req0_mac,
    input  logic             req1_start,
    input  logic [KEY_W-1:0] req1_key,
    input  logic [MSG_W-1:0] req1_msg,
    output logic             req1_ready,
    output logic [MAC_W-1:0] req1_mac,
    output logic             hmac_start,
    output logic [KEY_W-1:0] hmac_key,
    output logic [MSG_W-1:0] hmac_msg,
    input  logic [MAC_W-1:0] hmac_mac,
    input  logic             hmac_ready,
    output logic             grant,
    output logic             busy,
    output logic             err_timeout,
    output logic             err_overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [1:0]       pend;
    logic             last_grant;
    logic [CNT_W-1:0] wait_cnt;

    logic       rr_valid;
    logic       rr_sel;
    logic [1:0] start_v;
    logic [1:0] clr_v;
    logic       done;
    logic       timeout_hit;
    logic       cool;

    hmac_arb_rr u_rr (
        .pend  (pend),
        .last  (last_grant),
        .valid (rr_valid),
        .sel   (rr_sel)
    );

    assign start_v = {req1_start, req0_start};

    // A ready/abort pulse marks the first IDLE cycle after a
    // completion; hold off granting for that one cycle.
    assign cool = req0_ready | req1_ready;

    always_comb begin
        done        = 1'b0;
        timeout_hit = 1'b0;
        if (state == S_WAIT) begin
            if (hmac_ready) begin
                done = 1'b1;
            end else if (wait_cnt == CNT_LAST) begin
                done        = 1'b1;
                timeout_hit = 1'b1;
            end
        end
    end

    assign clr_v = done ? (grant ? 2'b10 : 2'b01) : 2'b00;

    assign busy     = (state != S_IDLE);
    assign hmac_key = busy ? (grant ? req1_key : req0_key) : '0;
    assign hmac_msg = busy ? (grant ? req1_msg : req0_msg) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pend        <= 2'b00;
            last_grant  <= 1'b1;
            grant       <= 1'b0;
            wait_cnt    <= '0;
            hmac_start  <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            req0_mac    <= '0;
            req1_mac    <= '0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            hmac_start  <= 1'b0;
            req0_ready  <= 1'b0;
            req1_ready  <= 1'b0;
            err_timeout <= 1'b0;
            // A start while still pending is lost; a start on the
            // completion edge also sees pend=1 and is dropped.
            err_overrun <= |(start_v & pend);
            pend        <= (pend | start_v) & ~clr_v;
            unique case (state)
                S_IDLE: begin
                    if (rr_valid && !cool) begin
                        grant      <= rr_sel;
                        hmac_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (done) begin
                        last_grant  <= grant;
                        err_timeout <= timeout_hit;
                        state       <= S_IDLE;
                        if (grant) begin
                            req1_ready <= 1'b1;
                            req1_mac   <= timeout_hit ? '0 : hmac_mac;
                        end else begin
                            req0_ready <= 1'b1;
                            req0_mac   <= timeout_hit ? '0 : hmac_mac;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
